// File: rtl/lpddr3_cmd_seq.sv
// lpddr3_cmd_seq -- LPDDR3 power-up / mode-register / refresh command sequencer.
//
// Holds CKE low for T_INIT cycles, raises it, waits T_CKE, issues
// precharge-all, loads MR2, MR3, MR1, MR0 and then sits in IDLE.
// In IDLE it forwards user commands one cycle after acceptance. It also
// interleaves a precharge-all + auto-refresh pair every T_REFI cycles.
// Every bus output is registered. A command occupies the bus for exactly
// one cycle. NOP is driven otherwise.
//
// Optional feature: define LPDDR3_CMD_SEQ_ZQCAL_EN to issue ZQCL after the
// last MRS, followed by a 512-cycle wait, before entering IDLE.
//
// Ports
//   SYS_CLK          in   sole clock, rising edge
//   RST              in   asynchronous active-high reset
//   cmd_valid/ready  in/out user command handshake (accepted when both high)
//   cmd_code         in   {cs_n,ras_n,cas_n,we_n} of the user command
//   cmd_ba, cmd_addr in   bank address / address of the user command
//   cke, cs_n, ras_n, cas_n, we_n, ba, a  out  registered command bus
//   init_done        out  initialization complete (held until reset)
//   ref_busy         out  refresh sequence in progress
//   ref_overrun      out  sticky: refresh interval expired while one was pending
module lpddr3_cmd_seq #(
  parameter int unsigned T_INIT = 20000,
  parameter int unsigned T_CKE  = 200,
  parameter int unsigned T_RP   = 6,
  parameter int unsigned T_MRD  = 4,
  parameter int unsigned T_RFC  = 52,
  parameter int unsigned T_REFI = 3120,
  parameter logic [15:0] MR0    = 16'h0520,
  parameter logic [15:0] MR1    = 16'h0044,
  parameter logic [15:0] MR2    = 16'h0008,
  parameter logic [15:0] MR3    = 16'h0000
) (
  input  logic        SYS_CLK,
  input  logic        RST,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [3:0]  cmd_code,
  input  logic [2:0]  cmd_ba,
  input  logic [15:0] cmd_addr,
  output logic        cke,
  output logic        cs_n,
  output logic        ras_n,
  output logic        cas_n,
  output logic        we_n,
  output logic [2:0]  ba,
  output logic [15:0] a,
  output logic        init_done,
  output logic        ref_busy,
  output logic        ref_overrun
);

  // A timing parameter of 0 is treated as a 1-cycle wait.
  function automatic int unsigned sat1(int unsigned v);
    return (v == 0) ? 1 : v;
  endfunction

  function automatic int unsigned max2(int unsigned x, int unsigned y);
    return (x > y) ? x : y;
  endfunction

`ifdef LPDDR3_CMD_SEQ_ZQCAL_EN
  localparam int unsigned ZQ_WAIT = 512;
`else
  localparam int unsigned ZQ_WAIT = 1;
`endif

  // One shared wait counter: only one wait state is ever active.
  localparam int unsigned MAX_WAIT = max2(max2(max2(sat1(T_INIT), sat1(T_CKE)),
                                               max2(sat1(T_RP), sat1(T_MRD))),
                                          max2(sat1(T_RFC), ZQ_WAIT));
  localparam int CW = $clog2(MAX_WAIT + 1);
  localparam int RW = $clog2(sat1(T_REFI) + 1);

  // The counter starts at 0 on state entry, so a wait of N ends when it reaches N-1.
  localparam logic [CW-1:0] LIM_INIT = CW'(sat1(T_INIT) - 1);
  localparam logic [CW-1:0] LIM_CKE  = CW'(sat1(T_CKE) - 1);
  localparam logic [CW-1:0] LIM_RP   = CW'(sat1(T_RP) - 1);
  localparam logic [CW-1:0] LIM_MRD  = CW'(sat1(T_MRD) - 1);
  localparam logic [CW-1:0] LIM_RFC  = CW'(sat1(T_RFC) - 1);
`ifdef LPDDR3_CMD_SEQ_ZQCAL_EN
  localparam logic [CW-1:0] LIM_ZQ   = CW'(ZQ_WAIT - 1);
`endif
  localparam logic [RW-1:0] LIM_REFI = RW'(sat1(T_REFI) - 1);

  typedef enum logic [3:0] {
    INIT_WAIT, CKE_WAIT, PREA, WAIT_RP, MRS, WAIT_MRD,
`ifdef LPDDR3_CMD_SEQ_ZQCAL_EN
    ZQCL, WAIT_ZQ,
`endif
    IDLE, REF_PREA, REF_WAIT_RP, REF, REF_WAIT_RFC
  } state_e;

  typedef struct packed {
    logic [3:0]  code;  // {cs_n, ras_n, cas_n, we_n}
    logic [2:0]  ba;
    logic [15:0] a;
  } bus_t;

  localparam bus_t BUS_RST  = '{code: 4'b1111, ba: 3'd0, a: 16'h0000};
  localparam bus_t BUS_NOP  = '{code: 4'b0111, ba: 3'd0, a: 16'h0000};
  localparam bus_t BUS_PREA = '{code: 4'b0010, ba: 3'd0, a: 16'h0400};
  localparam bus_t BUS_REF  = '{code: 4'b0001, ba: 3'd0, a: 16'h0000};

  state_e          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [2:0]      mr_cnt_q, mr_cnt_d;     // MRS commands issued so far
  logic [RW-1:0]   ref_cnt_q, ref_cnt_d;
  logic            ref_pending_q, ref_pending_d;
  logic            ref_overrun_q, ref_overrun_d;
  logic            init_done_q, init_done_d;
  logic            cmd_ready_q, cmd_ready_d;
  logic            ref_busy_q, ref_busy_d;
  logic            cke_q, cke_d;
  bus_t            bus_q, bus_d;
  logic            ref_expire;
  logic            ref_clear;

  always_comb begin
    // NOTE: every signal assigned in this block gets a default first, so no
    // path through the case statements can leave one unassigned (latch).
    state_d       = state_q;
    mr_cnt_d      = mr_cnt_q;
    ref_cnt_d     = ref_cnt_q;
    bus_d         = BUS_NOP;

    case (state_q)
      INIT_WAIT:    if (cnt_q == LIM_INIT) state_d = CKE_WAIT;
      CKE_WAIT:     if (cnt_q == LIM_CKE)  state_d = PREA;
      PREA:         state_d = WAIT_RP;
      WAIT_RP:      if (cnt_q == LIM_RP)   state_d = MRS;
      MRS:          state_d = WAIT_MRD;
      WAIT_MRD: begin
        if (cnt_q == LIM_MRD) begin
          if (mr_cnt_q == 3'd4) begin
`ifdef LPDDR3_CMD_SEQ_ZQCAL_EN
            state_d = ZQCL;
`else
            state_d = IDLE;
`endif
          end else begin
            state_d = MRS;
          end
        end
      end
`ifdef LPDDR3_CMD_SEQ_ZQCAL_EN
      ZQCL:         state_d = WAIT_ZQ;
      WAIT_ZQ:      if (cnt_q == LIM_ZQ)   state_d = IDLE;
`endif
      // cmd_ready is already low whenever a refresh is pending, so a
      // refresh can never collide with an accepted user command.
      IDLE:         if (ref_pending_q)     state_d = REF_PREA;
      REF_PREA:     state_d = REF_WAIT_RP;
      REF_WAIT_RP:  if (cnt_q == LIM_RP)   state_d = REF;
      REF:          state_d = REF_WAIT_RFC;
      REF_WAIT_RFC: if (cnt_q == LIM_RFC)  state_d = IDLE;
      default:      state_d = INIT_WAIT;
    endcase

    // Single-cycle states always leave, so "same state" means "still waiting".
    cnt_d = (state_d == state_q && state_q != IDLE) ? cnt_q + 1'b1 : '0;

    if (state_d == MRS) mr_cnt_d = mr_cnt_q + 1'b1;

    // Free-running refresh interval once initialization is complete.
    ref_expire = init_done_q && (ref_cnt_q == LIM_REFI);
    if (init_done_q) ref_cnt_d = ref_expire ? '0 : ref_cnt_q + 1'b1;

    ref_clear     = (state_d == REF);
    ref_pending_d = ref_expire | (ref_pending_q & ~ref_clear);
    ref_overrun_d = ref_overrun_q | (ref_expire & ref_pending_q & ~ref_clear);

    // Outputs are decoded from the next state so they line up with it.
    init_done_d = init_done_q | (state_d == IDLE);
    cmd_ready_d = (state_d == IDLE) && !ref_pending_d;
    ref_busy_d  = (state_d == REF_PREA) || (state_d == REF_WAIT_RP) ||
                  (state_d == REF) || (state_d == REF_WAIT_RFC);
    cke_d       = (state_d != INIT_WAIT);

    case (state_d)
      PREA, REF_PREA: bus_d = BUS_PREA;
      MRS: begin
        case (mr_cnt_q[1:0])
          2'd0:    bus_d = '{code: 4'b0000, ba: 3'd2, a: MR2};
          2'd1:    bus_d = '{code: 4'b0000, ba: 3'd3, a: MR3};
          2'd2:    bus_d = '{code: 4'b0000, ba: 3'd1, a: MR1};
          default: bus_d = '{code: 4'b0000, ba: 3'd0, a: MR0};
        endcase
      end
`ifdef LPDDR3_CMD_SEQ_ZQCAL_EN
      ZQCL:           bus_d = '{code: 4'b0110, ba: 3'd0, a: 16'h0400};
`endif
      REF:            bus_d = BUS_REF;
      IDLE: begin
        if (cmd_valid && cmd_ready_q)
          bus_d = '{code: cmd_code, ba: cmd_ba, a: cmd_addr};
      end
      default:        bus_d = BUS_NOP;
    endcase
  end

  always_ff @(posedge SYS_CLK or posedge RST) begin
    if (RST) begin
      state_q       <= INIT_WAIT;
      cnt_q         <= '0;
      mr_cnt_q      <= '0;
      ref_cnt_q     <= '0;
      ref_pending_q <= 1'b0;
      ref_overrun_q <= 1'b0;
      init_done_q   <= 1'b0;
      cmd_ready_q   <= 1'b0;
      ref_busy_q    <= 1'b0;
      cke_q         <= 1'b0;
      bus_q         <= BUS_RST;
    end else begin
      // NOTE: state registers use non-blocking assignments so every flop
      // samples the pre-edge value of every other flop.
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      mr_cnt_q      <= mr_cnt_d;
      ref_cnt_q     <= ref_cnt_d;
      ref_pending_q <= ref_pending_d;
      ref_overrun_q <= ref_overrun_d;
      init_done_q   <= init_done_d;
      cmd_ready_q   <= cmd_ready_d;
      ref_busy_q    <= ref_busy_d;
      cke_q         <= cke_d;
      bus_q         <= bus_d;
    end
  end

  assign cmd_ready                = cmd_ready_q;
  assign cke                      = cke_q;
  assign {cs_n, ras_n, cas_n, we_n} = bus_q.code;
  assign ba                       = bus_q.ba;
  assign a                        = bus_q.a;
  assign init_done                = init_done_q;
  assign ref_busy                 = ref_busy_q;
  assign ref_overrun              = ref_overrun_q;

endmodule

// File: tb/tb_lpddr3_cmd_seq.sv
// Self-checking bench for lpddr3_cmd_seq.
// dut1: T_INIT=10, T_CKE=5, T_REFI=100 -- init timing, refresh cadence,
//       random user traffic and a held ACT across a refresh.
// dut2: T_INIT=3 with T_CKE=T_RP=T_MRD=0 (zero treated as one cycle),
//       T_REFI=10 < refresh duration -- sticky ref_overrun.
// Expected behaviour comes from an arithmetic schedule of the command
// timeline (cycle numbers counted from reset release), not from DUT state.
module tb_lpddr3_cmd_seq;

  localparam int T_INIT1 = 10, T_CKE1 = 5, T_RP1 = 6, T_MRD1 = 4, T_RFC1 = 52, T_REFI1 = 100;
  localparam int T_INIT2 = 3,  T_CKE2 = 0, T_RP2 = 0, T_MRD2 = 0, T_RFC2 = 52, T_REFI2 = 10;

`ifdef LPDDR3_CMD_SEQ_ZQCAL_EN
  localparam int ZQ_EXTRA = 1 + 512;
`else
  localparam int ZQ_EXTRA = 0;
`endif

  // First IDLE cycle: PREA at T_INIT+T_CKE, T_RP wait, four (MRS + T_MRD wait).
  localparam int I1 = T_INIT1 + T_CKE1 + 1 + T_RP1 + 4 * (T_MRD1 + 1) + ZQ_EXTRA;
  localparam int I2 = T_INIT2 + 1 + 1 + 1 + 4 * (1 + 1) + ZQ_EXTRA;
  // Refresh sequence length: PREA + T_RP + REF + T_RFC.
  localparam int B1 = 2 + T_RP1 + T_RFC1;

  localparam logic [22:0] NOP_V  = {4'b0111, 3'd0, 16'h0000};
  localparam logic [22:0] PREA_V = {4'b0010, 3'd0, 16'h0400};
  localparam logic [22:0] REF_V  = {4'b0001, 3'd0, 16'h0000};
  localparam logic [27:0] RST_V  = {1'b0, 4'b1111, 3'd0, 16'h0000, 4'b0000};

  logic clk, RST;
  logic cmd_valid;
  logic [3:0] cmd_code;
  logic [2:0] cmd_ba;
  logic [15:0] cmd_addr;

  logic ready1, cke1, cs1, ras1, cas1, we1, done1, busy1, ovr1;
  logic [2:0] ba1;
  logic [15:0] a1;
  logic ready2, cke2, cs2, ras2, cas2, we2, done2, busy2, ovr2;
  logic [2:0] ba2;
  logic [15:0] a2;

  wire [22:0] bus1 = {cs1, ras1, cas1, we1, ba1, a1};
  wire [22:0] bus2 = {cs2, ras2, cas2, we2, ba2, a2};
  wire [27:0] all1 = {cke1, bus1, ready1, done1, busy1, ovr1};
  wire [27:0] all2 = {cke2, bus2, ready2, done2, busy2, ovr2};

  lpddr3_cmd_seq #(.T_INIT(T_INIT1), .T_CKE(T_CKE1), .T_RP(T_RP1), .T_MRD(T_MRD1),
                   .T_RFC(T_RFC1), .T_REFI(T_REFI1)) u_dut1 (
    .SYS_CLK(clk), .RST(RST), .cmd_valid(cmd_valid), .cmd_ready(ready1),
    .cmd_code(cmd_code), .cmd_ba(cmd_ba), .cmd_addr(cmd_addr),
    .cke(cke1), .cs_n(cs1), .ras_n(ras1), .cas_n(cas1), .we_n(we1), .ba(ba1), .a(a1),
    .init_done(done1), .ref_busy(busy1), .ref_overrun(ovr1));

  lpddr3_cmd_seq #(.T_INIT(T_INIT2), .T_CKE(T_CKE2), .T_RP(T_RP2), .T_MRD(T_MRD2),
                   .T_RFC(T_RFC2), .T_REFI(T_REFI2)) u_dut2 (
    .SYS_CLK(clk), .RST(RST), .cmd_valid(1'b0), .cmd_ready(ready2),
    .cmd_code(4'b0111), .cmd_ba(3'd0), .cmd_addr(16'h0000),
    .cke(cke2), .cs_n(cs2), .ras_n(ras2), .cas_n(cas2), .we_n(we2), .ba(ba2), .a(a2),
    .init_done(done2), .ref_busy(busy2), .ref_overrun(ovr2));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;       // rising edges since reset release
  bit pv, pr;             // last cycle: valid driven / ready expected
  logic [22:0] pcmd;      // last cycle: user command driven

  function automatic int sat(int v);
    return (v == 0) ? 1 : v;
  endfunction

  // Expected bus during initialization for given timing parameters.
  function automatic logic [22:0] init_bus(int c, int ti, int tc, int trp, int tmrd);
    int p, m0, st, k;
    p  = sat(ti) + sat(tc);
    m0 = p + 1 + sat(trp);
    st = sat(tmrd) + 1;
    if (c == 0) return {4'b1111, 3'd0, 16'h0000};
    if (c == p) return PREA_V;
    if (c >= m0 && (c - m0) % st == 0 && (c - m0) / st < 4) begin
      k = (c - m0) / st;
      case (k)
        0:       return {4'b0000, 3'd2, 16'h0008};
        1:       return {4'b0000, 3'd3, 16'h0000};
        2:       return {4'b0000, 3'd1, 16'h0044};
        default: return {4'b0000, 3'd0, 16'h0520};
      endcase
    end
`ifdef LPDDR3_CMD_SEQ_ZQCAL_EN
    if (c == m0 + 4 * st) return {4'b0110, 3'd0, 16'h0400};
`endif
    return NOP_V;
  endfunction

  // dut1 refresh schedule: pending shows at I1 + k*T_REFI (k>=1), PREA one
  // cycle later, REF after T_RP more, busy for B1 cycles.
  function automatic bit in_refresh_period(int c);
    return (c >= I1) && (c - I1 >= T_REFI1);
  endfunction

  function automatic bit m_ready(int c);
    if (c < I1) return 1'b0;
    if (in_refresh_period(c) && (c - I1) % T_REFI1 <= B1) return 1'b0;
    return 1'b1;
  endfunction

  function automatic bit m_busy(int c);
    int off;
    if (!in_refresh_period(c)) return 1'b0;
    off = (c - I1) % T_REFI1;
    return (off >= 1) && (off <= B1);
  endfunction

  function automatic logic [22:0] m_bus(int c);
    int off;
    if (c < I1) return init_bus(c, T_INIT1, T_CKE1, T_RP1, T_MRD1);
    if (in_refresh_period(c)) begin
      off = (c - I1) % T_REFI1;
      if (off == 1) return PREA_V;
      if (off == 2 + T_RP1) return REF_V;
    end
    return NOP_V;
  endfunction

  task automatic next_cycle();
    @(posedge clk);
    cyc++;
    @(negedge clk);
  endtask

  // Drive the next user request and remember whether it will be accepted.
  task automatic drive_stimulus(input bit hold_act);
    if (hold_act) begin
      cmd_valid = 1'b1;
      cmd_code  = 4'b0011;
      cmd_ba    = 3'd1;
      cmd_addr  = 16'h1234;
    end else begin
      cmd_valid = ($urandom_range(0, 1) == 1);
      cmd_code  = 4'($urandom);
      cmd_ba    = 3'($urandom);
      cmd_addr  = 16'($urandom);
    end
    pv   = cmd_valid;
    pr   = m_ready(cyc);
    pcmd = {cmd_code, cmd_ba, cmd_addr};
  endtask

  task automatic test_reset();
    RST = 1'b1;
    cmd_valid = 1'b0;
    cmd_code = 4'b0111;
    cmd_ba = 3'd0;
    cmd_addr = 16'h0000;
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_checks++;
    if (all1 !== RST_V) begin
      n_fail++;
      $display("FAIL reset_hold_dut1 got=%h exp=%h", all1, RST_V);
    end
    n_checks++;
    if (all2 !== RST_V) begin
      n_fail++;
      $display("FAIL reset_hold_dut2 got=%h exp=%h", all2, RST_V);
    end
    RST = 1'b0;
    cyc = 0;
    pv = 1'b0;
    pr = 1'b0;
    #1;
    n_checks++;
    if (all1 !== RST_V) begin
      n_fail++;
      $display("FAIL reset_release_dut1 got=%h exp=%h", all1, RST_V);
    end
  endtask

  task automatic test_init();
    logic [22:0] eb;
    for (int c = 1; c <= I1; c++) begin
      next_cycle();
      eb = (pv && pr) ? pcmd : m_bus(cyc);
      n_checks++;
      if (cke1 !== (cyc >= T_INIT1)) begin
        n_fail++;
        $display("FAIL init_cke1 cyc=%0d got=%b exp=%b", cyc, cke1, cyc >= T_INIT1);
      end
      n_checks++;
      if (bus1 !== eb) begin
        n_fail++;
        $display("FAIL init_bus1 cyc=%0d got=%h exp=%h", cyc, bus1, eb);
      end
      n_checks++;
      if (ready1 !== m_ready(cyc)) begin
        n_fail++;
        $display("FAIL init_ready1 cyc=%0d got=%b exp=%b", cyc, ready1, m_ready(cyc));
      end
      n_checks++;
      if (done1 !== (cyc >= I1)) begin
        n_fail++;
        $display("FAIL init_done1 cyc=%0d got=%b exp=%b", cyc, done1, cyc >= I1);
      end
      if (cyc < I2) begin
        n_checks++;
        if ({cke2, bus2} !== {cyc >= T_INIT2, init_bus(cyc, T_INIT2, T_CKE2, T_RP2, T_MRD2)}) begin
          n_fail++;
          $display("FAIL init_bus2 cyc=%0d got=%h exp=%h", cyc, {cke2, bus2},
                   {cyc >= T_INIT2, init_bus(cyc, T_INIT2, T_CKE2, T_RP2, T_MRD2)});
        end
      end
      n_checks++;
      if ({done2, ovr2} !== {cyc >= I2, 1'b0}) begin
        n_fail++;
        $display("FAIL init_done2 cyc=%0d got=%b exp=%b", cyc, {done2, ovr2}, {cyc >= I2, 1'b0});
      end
      drive_stimulus(1'b0);
    end
  endtask

  task automatic test_refresh_and_traffic(input int n, input bit hold_act);
    logic [22:0] eb;
    for (int i = 0; i < n; i++) begin
      next_cycle();
      eb = (pv && pr) ? pcmd : m_bus(cyc);
      n_checks++;
      if ({cke1, bus1} !== {1'b1, eb}) begin
        n_fail++;
        $display("FAIL traffic_bus1 cyc=%0d got=%h exp=%h", cyc, {cke1, bus1}, {1'b1, eb});
      end
      n_checks++;
      if (ready1 !== m_ready(cyc)) begin
        n_fail++;
        $display("FAIL traffic_ready1 cyc=%0d got=%b exp=%b", cyc, ready1, m_ready(cyc));
      end
      n_checks++;
      if ({done1, busy1, ovr1} !== {1'b1, m_busy(cyc), 1'b0}) begin
        n_fail++;
        $display("FAIL traffic_flags1 cyc=%0d got=%b exp=%b", cyc, {done1, busy1, ovr1},
                 {1'b1, m_busy(cyc), 1'b0});
      end
      // dut2: the third interval expiry finds the second request still pending.
      n_checks++;
      if (ovr2 !== (cyc >= I2 + 3 * T_REFI2)) begin
        n_fail++;
        $display("FAIL overrun2 cyc=%0d got=%b exp=%b", cyc, ovr2, cyc >= I2 + 3 * T_REFI2);
      end
      drive_stimulus(hold_act);
    end
  endtask

  task automatic test_reset_midrefresh();
    int guard = 0;
    while (!(in_refresh_period(cyc) && (cyc - I1) % T_REFI1 == 10) && guard < 2 * T_REFI1) begin
      next_cycle();
      drive_stimulus(1'b0);
      guard++;
    end
    n_checks++;
    if (guard >= 2 * T_REFI1) begin
      n_fail++;
      $display("FAIL midref_timeout cyc=%0d got=%0d exp<%0d", cyc, guard, 2 * T_REFI1);
    end
    n_checks++;
    if (busy1 !== 1'b1) begin
      n_fail++;
      $display("FAIL midref_busy cyc=%0d got=%b exp=1", cyc, busy1);
    end
    @(posedge clk);
    #2;
    RST = 1'b1;
    #1;
    n_checks++;
    if (all1 !== RST_V) begin
      n_fail++;
      $display("FAIL midref_async_dut1 got=%h exp=%h", all1, RST_V);
    end
    n_checks++;
    if (all2 !== RST_V) begin
      n_fail++;
      $display("FAIL midref_async_dut2 got=%h exp=%h", all2, RST_V);
    end
    @(negedge clk);
    @(negedge clk);
    RST = 1'b0;
    cyc = 0;
    pv = 1'b0;
    pr = 1'b0;
  endtask

  initial begin
    test_reset();
    test_init();
    test_refresh_and_traffic(250, 1'b0);
    test_refresh_and_traffic(150, 1'b1);
    test_reset_midrefresh();
    test_init();
    test_refresh_and_traffic(120, 1'b0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/lpddr3_cmd_seq.md
LPDDR3_CMD_SEQ -- requirements
Module: lpddr3_cmd_seq

Interface
REQ-001 SHALL have parameter T_INIT, default 20000, meaning cycles with CKE low after reset release.
REQ-002 SHALL have parameter T_CKE, default 200, meaning cycles from CKE high to first command.
REQ-003 SHALL have parameters T_RP, T_MRD, T_RFC, T_REFI with defaults 6, 4, 52, 3120, meaning cycle counts for precharge, mode-register, refresh and refresh-interval timing.
REQ-004 SHALL have parameters MR0..MR3, 16 bits each, defaults 16'h0520, 16'h0044, 16'h0008, 16'h0000, meaning mode-register payloads.
REQ-005 SYS_CLK  in  1  sole clock; all logic on rising edge.
REQ-006 RST  in  1  asynchronous, active-high reset.
REQ-007 cmd_valid  in  1  user command request; cmd_ready  out  1  user command accepted when both high.
REQ-008 cmd_code  in  4  {cs_n,ras_n,cas_n,we_n}; cmd_ba  in  3; cmd_addr  in  16.
REQ-009 cke, cs_n, ras_n, cas_n, we_n  out  1 each; ba  out  3; a  out  16: registered command bus feeding the ODDR output stage.
REQ-010 init_done  out  1  initialization complete; ref_busy  out  1  refresh sequence in progress; ref_overrun  out  1  sticky missed-refresh flag.

Function
REQ-011 Outputs SHALL be registered; each command SHALL be driven for exactly one cycle, NOP ({cs_n,ras_n,cas_n,we_n}=4'b0111, ba=0, a=0) otherwise.
REQ-012 FSM states SHALL be: INIT_WAIT, CKE_WAIT, PREA, WAIT_RP, MRS, WAIT_MRD, [ZQCL, WAIT_ZQ], IDLE, REF_PREA, REF_WAIT_RP, REF, REF_WAIT_RFC.
REQ-013 INIT_WAIT: cke=0 for T_INIT cycles, then cke=1 and go to CKE_WAIT.
REQ-014 CKE_WAIT: T_CKE cycles, then PREA issues precharge-all (4'b0010, a[10]=1, other bits 0), then WAIT_RP for T_RP cycles.
REQ-015 MRS (4'b0000) SHALL be issued four times in order MR2, MR3, MR1, MR0 with ba=2,3,1,0 and a=MRn, each followed by T_MRD NOP cycles.
REQ-016 Entering IDLE SHALL set init_done=1, held until reset.
REQ-017 cmd_ready SHALL be 1 only in IDLE with no refresh pending; an accepted command SHALL appear on the bus the next cycle, with cke held 1.
REQ-018 Refresh interval counter SHALL start at init_done and set ref_pending after T_REFI cycles, then reload and keep counting.
REQ-019 IDLE with ref_pending SHALL enter REF_PREA (precharge-all), wait T_RP, issue REF (4'b0001), wait T_RFC, return to IDLE; ref_pending clears on REF issue; ref_busy=1 from REF_PREA through REF_WAIT_RFC.
REQ-020 If cmd_valid and ref_pending become true in the same cycle, refresh SHALL win; cmd_ready stays 0 that cycle.
REQ-021 If the interval counter expires while ref_pending is already set, ref_overrun SHALL set and stay set until reset.
REQ-022 Wait counters SHALL be wide enough for the largest parameter; a parameter value 0 SHALL behave as 1 cycle.

Reset
REQ-023 RST high SHALL asynchronously force state INIT_WAIT, cke=0, cs_n=ras_n=cas_n=we_n=1, ba=0, a=0, cmd_ready=0, init_done=0, ref_busy=0, ref_overrun=0, ref_pending=0, all counters 0.
REQ-024 RST asserted mid-sequence (including during refresh) SHALL restart the full initialization after release.

Configuration
REQ-025 Macro LPDDR3_CMD_SEQ_ZQCAL_EN defined: after the last MRS wait, issue ZQCL (4'b0110, a[10]=1), wait 512 cycles, then IDLE; undefined: ZQCL/WAIT_ZQ absent and MRS wait goes directly to IDLE.

Verification
REQ-026 Reset release, T_INIT=10, T_CKE=5 -> cke rises 10 cycles after release; PREA with a=16'h0400 exactly 5 cycles later.
REQ-027 Init sequence -> MRS on ba=2,3,1,0 with a=16'h0008,16'h0000,16'h0044,16'h0520, spaced T_MRD+1 cycles; init_done=1 after the last wait (plus ZQCL and 512 cycles when macro defined).
REQ-028 T_REFI=100, no traffic -> PREA, REF every 100 cycles; ref_busy high for 1+T_RP+1+T_RFC cycles.
REQ-029 cmd_valid held with code 4'b0011 (ACT), ba=1, a=16'h1234 during refresh -> cmd_ready=0 until REF_WAIT_RFC ends; ACT then on bus one cycle after acceptance.
REQ-030 T_REFI=10, T_RFC=52 -> ref_overrun sets and stays set; RST pulse mid-refresh -> all outputs at reset values immediately, init restarts.
